// File: rtl/pfpu_regf_arb.sv
// PFPU register file port arbiter: shares the write port between datapath
// writeback and FIFO-buffered host writes, and lends read port 1 to the host.
// Optional writeback-stall statistics counter: define PFPU_REGF_ARB_STATS_EN.
module pfpu_regf_arb #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        dp_busy,
    input  logic [6:0]  dp_a1,
    input  logic        wb_en,
    input  logic [6:0]  wb_a,
    input  logic [31:0] wb_d,
    input  logic        h_we,
    input  logic        h_re,
    input  logic [6:0]  h_a,
    input  logic [31:0] h_di,
    output logic [31:0] h_do,
    output logic        h_ack,
    output logic        host_rd,
    output logic [6:0]  p1_a,
    input  logic [31:0] p1_d,
    output logic        p3_en,
    output logic [6:0]  p3_a,
    output logic [31:0] p3_d
`ifdef PFPU_REGF_ARB_STATS_EN
    ,
    output logic [15:0] wb_stall_cnt
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RWAIT,
        S_RISSUE,
        S_RDATA
    } state_t;

    state_t state_q, state_d;

    logic [31:0]   h_do_q, h_do_d;
    logic          h_ack_q, h_ack_d;
    logic          p3_en_q, p3_en_d;
    logic [6:0]    p3_a_q, p3_a_d;
    logic [31:0]   p3_d_q, p3_d_d;

    logic [38:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [38:0]   fifo_head;

    assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign fifo_head  = fifo_mem[rd_ptr_q];

    // Writeback always wins the port; the FIFO head waits behind it.
    assign pop = !wb_en && !fifo_empty;

    always_comb begin
        state_d = state_q;
        h_ack_d = 1'b0;
        h_do_d  = h_do_q;
        push    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!h_ack_q) begin
                    if (h_we) begin
                        if (!fifo_full) begin
                            push    = 1'b1;
                            h_ack_d = 1'b1;
                        end
                    end else if (h_re) begin
                        state_d = S_RWAIT;
                    end
                end
            end
            S_RWAIT: begin
                // Drained FIFO and idle write port: every host write has landed.
                if (fifo_empty && !p3_en_q && !dp_busy) begin
                    state_d = S_RISSUE;
                end
            end
            S_RISSUE: begin
                state_d = S_RDATA;
            end
            S_RDATA: begin
                h_do_d  = p1_d;
                h_ack_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        p3_en_d = 1'b0;
        p3_a_d  = p3_a_q;
        p3_d_d  = p3_d_q;
        if (wb_en) begin
            p3_en_d = 1'b1;
            p3_a_d  = wb_a;
            p3_d_d  = wb_d;
        end else if (!fifo_empty) begin
            p3_en_d = 1'b1;
            p3_a_d  = fifo_head[38:32];
            p3_d_d  = fifo_head[31:0];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {h_a, h_di};
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= S_IDLE;
            h_do_q   <= '0;
            h_ack_q  <= 1'b0;
            p3_en_q  <= 1'b0;
            p3_a_q   <= '0;
            p3_d_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            h_do_q   <= h_do_d;
            h_ack_q  <= h_ack_d;
            p3_en_q  <= p3_en_d;
            p3_a_q   <= p3_a_d;
            p3_d_q   <= p3_d_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign h_do    = h_do_q;
    assign h_ack   = h_ack_q;
    assign host_rd = (state_q == S_RISSUE);
    assign p1_a    = host_rd ? h_a : dp_a1;
    assign p3_en   = p3_en_q;
    assign p3_a    = p3_a_q;
    assign p3_d    = p3_d_q;

`ifdef PFPU_REGF_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (wb_en && !fifo_empty && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign wb_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pfpu_regf_arb.sv
// Directed and randomized bench for pfpu_regf_arb with a register file model
// and a queue-based reference for write-port ordering and host readback.
module tb_pfpu_regf_arb;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        dp_busy = 1'b0;
    logic [6:0]  dp_a1 = '0;
    logic        wb_en = 1'b0;
    logic [6:0]  wb_a = '0;
    logic [31:0] wb_d = '0;
    logic        h_we = 1'b0;
    logic        h_re = 1'b0;
    logic [6:0]  h_a = '0;
    logic [31:0] h_di = '0;
    logic [31:0] h_do;
    logic        h_ack;
    logic        host_rd;
    logic [6:0]  p1_a;
    logic [31:0] p1_d;
    logic        p3_en;
    logic [6:0]  p3_a;
    logic [31:0] p3_d;
`ifdef PFPU_REGF_ARB_STATS_EN
    logic [15:0] wb_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [128];
    logic [38:0] exp_q [$];
    logic [31:0] ref_mem [128];
    logic [6:0]  written [$];

    pfpu_regf_arb #(.FIFO_DEPTH(4)) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .dp_busy(dp_busy),
        .dp_a1(dp_a1),
        .wb_en(wb_en),
        .wb_a(wb_a),
        .wb_d(wb_d),
        .h_we(h_we),
        .h_re(h_re),
        .h_a(h_a),
        .h_di(h_di),
        .h_do(h_do),
        .h_ack(h_ack),
        .host_rd(host_rd),
        .p1_a(p1_a),
        .p1_d(p1_d),
        .p3_en(p3_en),
        .p3_a(p3_a),
        .p3_d(p3_d)
`ifdef PFPU_REGF_ARB_STATS_EN
        ,
        .wb_stall_cnt(wb_stall_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // Register file: write port plus read port 1 with one-cycle latency.
    always @(posedge sys_clk) begin
        if (p3_en) ram[p3_a] <= p3_d;
        p1_d <= ram[p1_a];
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic rnd_wb();
        wb_en   = ($urandom % 3) == 0;
        wb_a    = 7'($urandom % 64);
        wb_d    = $urandom;
        dp_busy = ($urandom % 4) == 0;
        dp_a1   = 7'($urandom);
    endtask

    // One cycle; the write port must carry last cycle's writeback, else the
    // oldest acknowledged host write, else nothing.
    task automatic cyc();
        logic        pw;
        logic [6:0]  pa;
        logic [31:0] pd;
        logic [38:0] e;
        pw = wb_en;
        pa = wb_a;
        pd = wb_d;
        step();
        if (pw) begin
            chk("rnd_wb_en", p3_en, 1);
            chk("rnd_wb_a", p3_a, pa);
            chk("rnd_wb_d", p3_d, pd);
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rnd_fifo_en", p3_en, 1);
            chk("rnd_fifo_a", p3_a, e[38:32]);
            chk("rnd_fifo_d", p3_d, e[31:0]);
        end else begin
            chk("rnd_idle_en", p3_en, 0);
        end
    endtask

    initial begin
        bit          is_wr;
        bit          acked;
        logic [6:0]  ra;
        logic [31:0] rd;

        for (int i = 0; i < 128; i++) ram[i] = '0;

        // Reset state
        step();
        step();
        chk("rst_h_do", h_do, 0);
        chk("rst_h_ack", h_ack, 0);
        chk("rst_host_rd", host_rd, 0);
        chk("rst_p3_en", p3_en, 0);
        chk("rst_p3_a", p3_a, 0);
        chk("rst_p3_d", p3_d, 0);
`ifdef PFPU_REGF_ARB_STATS_EN
        chk("rst_stall", wb_stall_cnt, 0);
`endif
        sys_rst = 1'b0;
        step();

        // Writeback only
        wb_en = 1'b1;
        wb_a  = 7'h05;
        wb_d  = 32'hDEADBEEF;
        step();
        chk("wb_en", p3_en, 1);
        chk("wb_a", p3_a, 7'h05);
        chk("wb_d", p3_d, 32'hDEADBEEF);
        wb_en = 1'b0;
        step();
        chk("wb_off", p3_en, 0);

        // Host writes queued behind continuous writeback
        wb_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wb_a = 7'(8'h20 + i);
            wb_d = 32'hA000 + i;
            h_we = 1'b1;
            h_a  = 7'(8'h10 + i);
            h_di = i + 1;
            step();
            chk("cont_ack", h_ack, 1);
            chk("cont_wb_a", p3_a, 8'h20 + i);
            h_we = 1'b0;
            step();
            chk("cont_gap", h_ack, 0);
        end
        h_we = 1'b1;
        h_a  = 7'h14;
        h_di = 32'd5;
        step();
        chk("full_noack", h_ack, 0);
`ifdef PFPU_REGF_ARB_STATS_EN
        chk("stall_cnt", wb_stall_cnt, 8);
`endif
        wb_en = 1'b0;
        step();
        chk("full_noack2", h_ack, 0);
        chk("drain0_a", p3_a, 7'h10);
        chk("drain0_d", p3_d, 1);
        step();
        chk("fifth_ack", h_ack, 1);
        chk("drain1_a", p3_a, 7'h11);
        chk("drain1_d", p3_d, 2);
        h_we = 1'b0;
        for (int i = 2; i < 5; i++) begin
            step();
            chk("drain_en", p3_en, 1);
            chk("drain_a", p3_a, 8'h10 + i);
            chk("drain_d", p3_d, i + 1);
        end
        step();
        chk("drain_done", p3_en, 0);

        // Push and pop in the same cycle at depth-1
        wb_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            h_we = 1'b1;
            h_a  = 7'(8'h40 + i);
            h_di = 32'h100 + i;
            step();
            chk("d1_fill_ack", h_ack, 1);
            h_we = 1'b0;
            step();
        end
        wb_en = 1'b0;
        h_we  = 1'b1;
        h_a   = 7'h43;
        h_di  = 32'h103;
        step();
        chk("d1_pp_ack", h_ack, 1);
        chk("d1_pp_a", p3_a, 7'h40);
        chk("d1_pp_d", p3_d, 32'h100);
        wb_en = 1'b1;
        h_we  = 1'b0;
        step();
        h_we = 1'b1;
        h_a  = 7'h44;
        h_di = 32'h104;
        step();
        chk("d1_last_ack", h_ack, 1);
        h_we = 1'b0;
        step();
        h_we = 1'b1;
        h_a  = 7'h45;
        h_di = 32'h105;
        step();
        chk("d1_full_noack", h_ack, 0);
        h_we  = 1'b0;
        wb_en = 1'b0;
        for (int i = 1; i < 5; i++) begin
            step();
            chk("d1_drain_en", p3_en, 1);
            chk("d1_drain_a", p3_a, 8'h40 + i);
            chk("d1_drain_d", p3_d, 32'h100 + i);
        end
        step();
        chk("d1_drain_done", p3_en, 0);

        // Simultaneous write and read: only the write happens
        h_we = 1'b1;
        h_re = 1'b1;
        h_a  = 7'h30;
        h_di = 32'h1234;
        step();
        chk("sim_ack", h_ack, 1);
        h_we = 1'b0;
        h_re = 1'b0;
        step();
        chk("sim_ack_once", h_ack, 0);
        chk("sim_p3_a", p3_a, 7'h30);
        chk("sim_p3_d", p3_d, 32'h1234);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("sim_no_read_ack", h_ack, 0);
            chk("sim_no_host_rd", host_rd, 0);
        end

        // Read after write
        h_we = 1'b1;
        h_a  = 7'h7F;
        h_di = 32'hCAFEF00D;
        step();
        chk("raw_wr_ack", h_ack, 1);
        h_we = 1'b0;
        step();
        h_re = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (h_ack) break;
        end
        chk("raw_ack", h_ack, 1);
        chk("raw_data", h_do, 32'hCAFEF00D);
        h_re = 1'b0;
        step();

        // Uncontended read latency
        h_re = 1'b1;
        h_a  = 7'h05;
        step();
        chk("rd_t1_ack", h_ack, 0);
        chk("rd_t1_host_rd", host_rd, 0);
        step();
        chk("rd_t2_host_rd", host_rd, 1);
        chk("rd_t2_p1_a", p1_a, 7'h05);
        step();
        chk("rd_t3_host_rd", host_rd, 0);
        chk("rd_t3_ack", h_ack, 0);
        step();
        chk("rd_t4_ack", h_ack, 1);
        chk("rd_t4_data", h_do, 32'hDEADBEEF);
        h_re = 1'b0;
        step();
        chk("rd_t5_ack", h_ack, 0);

        // Read held off by a busy datapath
        dp_busy = 1'b1;
        h_re    = 1'b1;
        h_a     = 7'h10;
        for (int i = 0; i < 20; i++) begin
            dp_a1 = 7'(i + 3);
            step();
            chk("busy_p1_a", p1_a, i + 3);
            chk("busy_no_ack", h_ack, 0);
            chk("busy_no_host_rd", host_rd, 0);
        end
        dp_busy = 1'b0;
        step();
        chk("busy_issue_host_rd", host_rd, 1);
        chk("busy_issue_p1_a", p1_a, 7'h10);
        step();
        chk("busy_rdata_ack", h_ack, 0);
        step();
        chk("busy_ack", h_ack, 1);
        chk("busy_data", h_do, 1);
        h_re  = 1'b0;
        dp_a1 = '0;
        step();

        // Reset in the RDATA cycle
        h_re = 1'b1;
        h_a  = 7'h05;
        step();
        step();
        step();
        #1 sys_rst = 1'b1;
        #1;
        chk("rrst_h_ack", h_ack, 0);
        chk("rrst_h_do", h_do, 0);
        chk("rrst_host_rd", host_rd, 0);
        chk("rrst_p3_en", p3_en, 0);
        chk("rrst_p3_a", p3_a, 0);
        chk("rrst_p3_d", p3_d, 0);
        h_re = 1'b0;
        step();
        chk("rrst_held_ack", h_ack, 0);
        sys_rst = 1'b0;
        step();
        chk("rrst_rel_ack", h_ack, 0);

        // Reset discards a queued host write
        wb_en = 1'b1;
        wb_a  = 7'h01;
        h_we  = 1'b1;
        h_a   = 7'h50;
        h_di  = 32'h55;
        step();
        chk("wrst_ack", h_ack, 1);
        h_we = 1'b0;
        #1 sys_rst = 1'b1;
        wb_en = 1'b0;
        step();
        sys_rst = 1'b0;
        step();
        chk("wrst_p3_en0", p3_en, 0);
        step();
        chk("wrst_p3_en1", p3_en, 0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 80; n++) begin
            is_wr = (written.size() == 0) || ($urandom % 2 == 0);
            if (is_wr) begin
                ra   = 7'h40 | 7'($urandom % 64);
                rd   = $urandom;
                h_we = 1'b1;
                h_a  = ra;
                h_di = rd;
            end else begin
                ra   = written[$urandom % written.size()];
                h_re = 1'b1;
                h_a  = ra;
            end
            acked = 1'b0;
            for (int c = 0; c < 200 && !acked; c++) begin
                rnd_wb();
                cyc();
                if (h_ack) acked = 1'b1;
            end
            chk("rnd_ack", h_ack, 1);
            if (is_wr) begin
                exp_q.push_back({ra, rd});
                ref_mem[ra] = rd;
                written.push_back(ra);
            end else begin
                chk("rnd_read", h_do, ref_mem[ra]);
            end
            h_we = 1'b0;
            h_re = 1'b0;
            for (int g = 0; g < 1 + int'($urandom % 3); g++) begin
                rnd_wb();
                cyc();
            end
        end
        wb_en   = 1'b0;
        dp_busy = 1'b0;
        for (int g = 0; g < 8; g++) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
